// File: rtl/dmem_responder.sv
// dmem_responder: tagged memory responder for the data-memory bus.
// Accepts at most one LOAD or STORE per cycle. An accepted command is
// acknowledged in the same cycle with the lowest free tag. Load data is
// returned with its tag LATENCY cycles after acceptance.
//
// Ports
//   clock              rising-edge clock
//   reset              synchronous, active-high
//   proc2mem_command   0 NONE, 1 LOAD, 2 STORE, 3 NONE
//   proc2mem_addr      byte address (bits [2:0] ignored)
//   proc2mem_data      store data
//   mem2proc_response  combinational accept tag (0 = rejected)
//   mem2proc_data      registered load return data (0 when idle)
//   mem2proc_tag       registered load return tag (0 when idle)
module dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned NUM_TAGS    = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned HI = 3 + AW;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [63:0]         mem [DEPTH_WORDS];
  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] free_next;
  logic [3:0]          pipe_tag  [LATENCY];
  logic [63:0]         pipe_data [LATENCY];

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic [3:0]    cand;
  logic          accept;
  logic          load_acc;
  logic          store_acc;
  logic [63:0]   rd_data;
  logic          unused_addr_bits;

  assign word_idx         = proc2mem_addr[3 +: AW];
  assign in_range         = (proc2mem_addr >> HI) == '0;
  assign rd_data          = mem[word_idx];
  assign unused_addr_bits = ^proc2mem_addr[2:0];

  // Lowest-numbered free tag; bit i of the mask stands for tag i+1.
  always_comb begin
    cand = 4'd0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (free_mask[i]) cand = 4'(i + 1);
    end
  end

  // Accept decision; response is forced to 0 during reset.
  always_comb begin
    accept    = !reset && in_range && (cand != 4'd0) &&
                (proc2mem_command == CMD_LOAD || proc2mem_command == CMD_STORE);
    load_acc  = accept && (proc2mem_command == CMD_LOAD);
    store_acc = accept && (proc2mem_command == CMD_STORE);
    mem2proc_response = accept ? cand : 4'd0;
  end

  // Tag pool update: the tag on the outputs this cycle is released, the
  // newly accepted load's tag is claimed. They can never be the same tag.
  always_comb begin
    free_next = free_mask;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      if (mem2proc_tag == 4'(i + 1)) free_next[i] = 1'b1;
      if (load_acc && cand == 4'(i + 1)) free_next[i] = 1'b0;
    end
  end

  // Backing store; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (store_acc) mem[word_idx] <= proc2mem_data;
  end

  // Tag pool and return pipeline; empty stages carry tag 0 and data 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_mask <= '1;
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_tag[i]  <= 4'd0;
        pipe_data[i] <= 64'd0;
      end
    end else begin
      free_mask    <= free_next;
      pipe_tag[0]  <= load_acc ? cand : 4'd0;
      pipe_data[0] <= load_acc ? rd_data : 64'd0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign mem2proc_tag  = pipe_tag[LATENCY-1];
  assign mem2proc_data = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 4;
  localparam int NT  = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  resp, tag, resp2, tag2;
  logic [63:0] rdata, rdata2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT), .NUM_TAGS(NT)) dut (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp), .mem2proc_data(rdata),
    .mem2proc_tag(tag));

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT), .NUM_TAGS(2)) dut2 (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp2), .mem2proc_data(rdata2),
    .mem2proc_tag(tag2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image plus a list of loads in flight, each
  // with the cycle it must appear on the outputs.
  typedef struct {
    int          tag;
    logic [63:0] data;
    bit          known;
    int          due;
  } ent_t;

  ent_t        q[$];
  logic [63:0] mmem  [1024];
  bit          known [1024];
  bit          busy  [16];
  int          n = 0;
  int          cand, exp_r, widx;

  always @(negedge clock) begin
    n++;
    if (reset) begin
      chk("resp_in_reset", 64'(resp), 64'd0);
      q.delete();
    end else begin
      foreach (busy[i]) busy[i] = 1'b0;
      foreach (q[i]) busy[q[i].tag] = 1'b1;
      cand = 0;
      for (int t = NT; t >= 1; t--) if (!busy[t]) cand = t;
      widx  = int'(addr[12:3]);
      exp_r = ((cmd == 2'd1 || cmd == 2'd2) && addr < 32'd8192) ? cand : 0;
      chk("response", 64'(resp), 64'(exp_r));
      if (q.size() > 0 && q[0].due == n) begin
        chk("ret_tag", 64'(tag), 64'(q[0].tag));
        if (q[0].known) chk("ret_data", rdata, q[0].data);
        void'(q.pop_front());
      end else begin
        chk("idle_tag", 64'(tag), 64'd0);
        chk("idle_data", rdata, 64'd0);
      end
      if (exp_r != 0 && cmd == 2'd1)
        q.push_back(ent_t'{exp_r, mmem[widx], known[widx], n + LAT});
      if (exp_r != 0 && cmd == 2'd2) begin
        mmem[widx]  = wdata;
        known[widx] = 1'b1;
      end
    end
  end

  // One bus cycle: drive just after the edge, return just after the check point.
  task automatic step(input logic r, input logic [1:0] c, input logic [31:0] a,
                      input logic [63:0] d);
    @(posedge clock);
    #1;
    reset = r; cmd = c; addr = a; wdata = d;
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 2'd0, 32'd0, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic        rr;
    int          exp2 [6];
    reset = 1'b1; cmd = 2'd0; addr = 32'd0; wdata = 64'd0;
    repeat (3) step(1'b1, 2'd0, 32'd0, 64'd0);

    // Idle after reset
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'd0, 32'd0, 64'd0);
      chk("lit_idle_resp", 64'(resp), 64'd0);
      chk("lit_idle_tag", 64'(tag), 64'd0);
      chk("lit_idle_data", rdata, 64'd0);
    end

    // Store then load of one word
    step(1'b0, 2'd2, 32'd8, 64'd24);
    chk("lit_st8_resp", 64'(resp), 64'd1);
    step(1'b0, 2'd1, 32'd8, 64'd0);
    chk("lit_ld8_resp", 64'(resp), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 2'd0, 32'd0, 64'd0);
      if (k == 4) begin
        chk("lit_ld8_tag", 64'(tag), 64'd1);
        chk("lit_ld8_data", rdata, 64'd24);
      end else begin
        chk("lit_ld8_notag", 64'(tag), 64'd0);
      end
    end

    // Preload words 0..63
    for (int i = 0; i < 8; i++) step(1'b0, 2'd2, 32'(i * 8), 64'(i));
    for (int i = 8; i < 64; i++) step(1'b0, 2'd2, 32'(i * 8), {$urandom, $urandom});
    idle(6);

    // Back-to-back loads of words 0..4
    for (int j = 0; j <= 8; j++) begin
      step(1'b0, (j < 5) ? 2'd1 : 2'd0, 32'(j * 8), 64'd0);
      if (j < 5) chk("lit_burst_resp", 64'(resp), 64'(j + 1));
      if (j >= 4) begin
        chk("lit_burst_tag", 64'(tag), 64'(j - 3));
        chk("lit_burst_data", rdata, 64'(j - 4));
      end else begin
        chk("lit_burst_notag", 64'(tag), 64'd0);
      end
    end
    idle(4);

    // Load, overlapping store, load of the same word
    step(1'b0, 2'd1, 32'd16, 64'd0);
    chk("lit_ord_ld1", 64'(resp), 64'd1);
    step(1'b0, 2'd2, 32'd16, 64'd99);
    chk("lit_ord_st", 64'(resp), 64'd2);
    step(1'b0, 2'd1, 32'd16, 64'd0);
    chk("lit_ord_ld2", 64'(resp), 64'd2);
    for (int k = 3; k <= 7; k++) begin
      step(1'b0, 2'd0, 32'd0, 64'd0);
      if (k == 4) begin
        chk("lit_ord_old_tag", 64'(tag), 64'd1);
        chk("lit_ord_old_data", rdata, 64'd2);
      end
      if (k == 6) begin
        chk("lit_ord_new_tag", 64'(tag), 64'd2);
        chk("lit_ord_new_data", rdata, 64'd99);
      end
    end
    idle(4);

    // Out-of-range load
    step(1'b0, 2'd1, 32'd8192, 64'd0);
    chk("lit_oor_resp", 64'(resp), 64'd0);
    chk("lit_oor_resp2", 64'(resp2), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 2'd0, 32'd0, 64'd0);
      chk("lit_oor_notag", 64'(tag), 64'd0);
    end

    // Reset with a load in flight
    step(1'b0, 2'd1, 32'd24, 64'd0);
    chk("lit_rst_ld", 64'(resp), 64'd1);
    step(1'b0, 2'd0, 32'd0, 64'd0);
    step(1'b1, 2'd0, 32'd0, 64'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'd0, 32'd0, 64'd0);
      chk("lit_rst_notag", 64'(tag), 64'd0);
      chk("lit_rst_notag2", 64'(tag2), 64'd0);
    end
    step(1'b0, 2'd1, 32'd8, 64'd0);
    chk("lit_rst_after", 64'(resp), 64'd1);
    idle(6);

    // Two-tag instance stalls until a tag comes back
    exp2 = '{1, 2, 0, 0, 0, 1};
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 2'd1, 32'd0, 64'd0);
      chk("lit_stall_resp2", 64'(resp2), 64'(exp2[k]));
      if (k == 4) chk("lit_stall_tag2", 64'(tag2), 64'd1);
    end
    idle(6);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) ra = 32'h2000 + 32'($urandom_range(0, 65535));
      else ra = (32'($urandom_range(0, 63)) << 3) | 32'($urandom_range(0, 7));
      rr = ($urandom_range(0, 199) == 0);
      step(rr, 2'($urandom_range(0, 3)), ra, {$urandom, $urandom});
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Synthesizable tagged memory responder for the data-memory bus: the memory end of the protocol the dcache drives via `Dcache2Dmem_command/addr/data`. It accepts one load or store per cycle, acknowledges accepted commands with a nonzero tag in the same cycle, and returns load data with the matching tag a fixed number of cycles later. It replaces the behavioural memory model in dcache benches and serves as the on-chip backing store for FPGA builds.

## Interface

- `DEPTH_WORDS`, 1024: number of 64-bit words; power of two.
- `LATENCY`, 4: cycles from load acceptance to data return; ≥1.
- `NUM_TAGS`, 15: size of the tag pool; 1..15. Tags are numbered 1..NUM_TAGS.

- `clock`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `proc2mem_command`  in  2  0 = NONE, 1 = LOAD, 2 = STORE, 3 = treated as NONE.
- `proc2mem_addr`  in  `XLEN`  byte address; bits [2:0] ignored.
- `proc2mem_data`  in  64  store data.
- `mem2proc_response`  out  4  combinational; nonzero tag = command accepted this cycle; 0 = rejected.
- `mem2proc_data`  out  64  registered; load data, valid when `mem2proc_tag` ≠ 0.
- `mem2proc_tag`  out  4  registered; tag of the completing load, 0 = none.

## Operation

- Word index = `addr[3 +: log2(DEPTH_WORDS)]`. An address ≥ DEPTH_WORDS×8 is out of range. Such a command gets response 0 and has no side effect.
- Free-tag mask has NUM_TAGS bits; all tags are free after reset. The candidate tag is the lowest-numbered free tag, or 0 if none is free.
- LOAD, in range, candidate ≠ 0:
  - response = candidate.
  - At the edge, the tag is marked busy.
  - The array word is read at acceptance and captured with the tag into stage 0 of a LATENCY-deep return pipeline.
- STORE, in range, candidate ≠ 0:
  - response = candidate; the tag is not allocated.
  - The array word is written at the edge.
  - The tag is never returned on `mem2proc_tag`.
- Any command with no free tag gets response 0 and is ignored; the requester retries.
- Return pipeline:
  - Advances one stage per cycle.
  - The last stage drives `mem2proc_tag`/`mem2proc_data`. Outputs are 0 when that stage is empty.
  - At the edge that ends a return cycle, the returned tag is freed.
- Ordering:
  - Data is sampled at acceptance, so a load sees every store accepted in earlier cycles and none accepted later.
  - Only one command is accepted per cycle, so no same-cycle load/store conflict exists.
  - Returns occur in acceptance order, at most one per cycle.
- Array contents are not reset. Benches preload the array with stores.

## Timing

- Reset values: `mem2proc_tag` = 0, `mem2proc_data` = 0, return pipeline empty, all tags free. During reset, `mem2proc_response` = 0.
- Load accepted in cycle c → tag/data are on the outputs for exactly one cycle, cycle c+LATENCY. That tag becomes allocatable again in cycle c+LATENCY+1.
- A store accepted in cycle c is visible to a load accepted in cycle c+1.
- Sustained throughput is 1 load/cycle iff NUM_TAGS ≥ LATENCY+1. Otherwise loads stall via response 0.
- Reset asserted mid-flight: all in-flight loads are dropped, no tags are returned, and the pool is fully freed on the next cycle.
- `mem2proc_response` depends combinationally only on command, address and the registered free mask. There is no path from `mem2proc_data` or `mem2proc_tag`.

## Test plan

- Reset, then NONE for 5 cycles → response 0, tag 0, data 0 every cycle.
- STORE addr 8 data 24 (LATENCY=4) → response 1. LOAD addr 8 next cycle (c) → response 1; cycle c+4: tag 1, data 24 for one cycle; tag 0 at c+5.
- After storing word i = i for i = 0..7, LOADs to addr 0, 8, 16, 24, 32 on consecutive cycles → responses 1..5; returns on cycles c+4..c+8 with tags 1..5 and data 0..4, in order.
- NUM_TAGS=2, LATENCY=4: LOADs in cycles c, c+1, c+2 → responses 1, 2, 0. Retry each cycle → accepted in cycle c+5 with tag 1.
- LOAD addr 16 (old value 2) in cycle c, then STORE addr 16 data 99 in cycle c+1 → return at c+4 carries 2. A LOAD at c+2 returns 99.
- LOAD addr 8192 with DEPTH_WORDS=1024 → response 0 and no return. LOAD accepted, then reset at c+2 → no tag appears; after reset the next load gets tag 1.
